// File: rtl/dm_ctrl_pkg.sv
// Shared types and constants for the debug-module hart controller:
// FSM states, abstractcs.cmderr codes, flag bit positions and command fields.
package dm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUNNING  = 3'd0,
    ST_HALTING  = 3'd1,
    ST_HALTED   = 3'd2,
    ST_GO       = 3'd3,
    ST_CMD_EXEC = 3'd4,
    ST_RESUME   = 3'd5
  } state_e;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

  localparam int FLAG_GO     = 0;
  localparam int FLAG_RESUME = 1;

  localparam int CMDTYPE_MSB  = 31;
  localparam int CMDTYPE_LSB  = 24;
  localparam int CMD_TRANSFER = 17;
  localparam int CMD_POSTEXEC = 18;

  // An access-register command only needs the hart to run the program buffer
  // or ROM when it transfers data or asks for post-execution.
  function automatic logic cmd_needs_exec(input logic [31:0] cmd);
    return cmd[CMD_TRANSFER] | cmd[CMD_POSTEXEC];
  endfunction

endpackage

// File: rtl/dm_cmderr_reg.sv
// Sticky abstractcs.cmderr register: the first error after a clear is kept,
// and a clear wins over an error reported in the same cycle.
module dm_cmderr_reg
  import dm_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       set,
  input  logic [2:0] code,
  input  logic       clear,
  output logic [2:0] cmderr
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmderr <= CMDERR_NONE;
    end else if (clear) begin
      cmderr <= CMDERR_NONE;
    end else if (set && (cmderr == CMDERR_NONE)) begin
      cmderr <= code;
    end
  end

endmodule

// File: rtl/dm_hart_ctrl_fsm.sv
// Halt / resume / abstract-command sequencer for the hart-facing debug memory.
// Drives the go/resume flags the hart polls and tracks abstractcs status.
//
// state       | meaning
// ------------+----------------------------------------------------------
// RUNNING     | hart running, no debug request outstanding
// HALTING     | debug_req asserted, waiting for HALTED or timeout
// HALTED      | hart parked in the debug loop, accepts commands / resume
// GO          | go flag raised, waiting for hart to write GOING
// CMD_EXEC    | hart executing the command, waiting for HALTED/EXCEPTION
// RESUME      | resume flag raised, waiting for hart to write RESUMING
module dm_hart_ctrl_fsm
  import dm_ctrl_pkg::*;
#(
  parameter int HaltTimeout = 1024,
  parameter int CntWidth    = $clog2(HaltTimeout + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        haltreq_i,
  input  logic        resumereq_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic        cmderr_clear_i,
  input  logic        halted_we_i,
  input  logic        going_we_i,
  input  logic        resuming_we_i,
  input  logic        exception_we_i,
  output logic        debug_req_o,
  output logic [63:0] flags_o,
  output logic [31:0] cmd_o,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  output logic        halted_o,
  output logic        resumeack_o,
  output logic        halt_timeout_o
);

  // The halt wait counts down from HaltTimeout-1 and gives up at zero, which
  // keeps the HALTING window exactly HaltTimeout cycles long.
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(HaltTimeout - 1);

  state_e              state, state_next;
  logic [CntWidth-1:0] cnt, cnt_next;
  logic [31:0]         cmd_q, cmd_next;
  logic                halted_q, halted_next;
  logic                ack_q, ack_next;
  logic                tmo_q, tmo_next;
  logic                err_set;
  logic [2:0]          err_code;
  logic                busy;
  logic                cmd_supported;

  assign busy          = (state == ST_GO) || (state == ST_CMD_EXEC);
  assign cmd_supported = (cmd_i[CMDTYPE_MSB:CMDTYPE_LSB] == 8'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_RUNNING;
      cnt      <= '0;
      cmd_q    <= '0;
      halted_q <= 1'b0;
      ack_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      cmd_q    <= cmd_next;
      halted_q <= halted_next;
      ack_q    <= ack_next;
      tmo_q    <= tmo_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    cmd_next    = cmd_q;
    halted_next = halted_q;
    ack_next    = ack_q;
    tmo_next    = tmo_q;
    err_set     = 1'b0;
    err_code    = CMDERR_NONE;

    unique case (state)
      ST_RUNNING: begin
        if (halted_we_i) begin
          state_next  = ST_HALTED;
          halted_next = 1'b1;
        end else if (haltreq_i) begin
          state_next = ST_HALTING;
          cnt_next   = CntLoad;
        end
      end
      ST_HALTING: begin
        if (halted_we_i) begin
          state_next  = ST_HALTED;
          halted_next = 1'b1;
        end else if (cnt == '0) begin
          state_next = ST_RUNNING;
          tmo_next   = 1'b1;
        end else begin
          cnt_next = cnt - CntWidth'(1);
        end
      end
      ST_HALTED: begin
        if (cmd_valid_i) begin
          if (!cmd_supported) begin
            err_set  = 1'b1;
            err_code = CMDERR_NOTSUP;
          end else begin
            cmd_next = cmd_i;
            if (cmd_needs_exec(cmd_i)) state_next = ST_GO;
          end
        end else if (resumereq_i && !haltreq_i) begin
          state_next  = ST_RESUME;
          halted_next = 1'b0;
          ack_next    = 1'b0;
        end
      end
      ST_GO: begin
        if (going_we_i) state_next = ST_CMD_EXEC;
      end
      ST_CMD_EXEC: begin
        if (exception_we_i) begin
          state_next = ST_HALTED;
          err_set    = 1'b1;
          err_code   = CMDERR_EXCEPTION;
        end else if (halted_we_i) begin
          state_next = ST_HALTED;
        end
      end
      ST_RESUME: begin
        if (resuming_we_i) begin
          state_next = ST_RUNNING;
          ack_next   = 1'b1;
        end
      end
      default: state_next = ST_RUNNING;
    endcase

    // Commands arriving outside the idle halted state are rejected here;
    // an exception reported in the same cycle takes precedence.
    if (cmd_valid_i && !err_set) begin
      if (busy) begin
        err_set  = 1'b1;
        err_code = CMDERR_BUSY;
      end else if (state != ST_HALTED) begin
        err_set  = 1'b1;
        err_code = CMDERR_HALTRESUME;
      end
    end
  end

  dm_cmderr_reg u_cmderr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .set    (err_set),
    .code   (err_code),
    .clear  (cmderr_clear_i),
    .cmderr (cmderr_o)
  );

  always_comb begin
    flags_o              = '0;
    flags_o[FLAG_GO]     = (state == ST_GO);
    flags_o[FLAG_RESUME] = (state == ST_RESUME);
  end

  assign debug_req_o    = (state == ST_HALTING);
  assign busy_o         = busy;
  assign cmd_o          = cmd_q;
  assign halted_o       = halted_q;
  assign resumeack_o    = ack_q;
  assign halt_timeout_o = tmo_q;

endmodule

// File: tb/tb_dm_hart_ctrl_fsm.sv
// Self-checking bench for dm_hart_ctrl_fsm: a phase-flag model compared every
// cycle, plus directed halt/command/error/resume/timeout/reset scenarios.
module tb_dm_hart_ctrl_fsm;

  localparam int HT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        haltreq = 1'b0, resumereq = 1'b0, cmd_valid = 1'b0, cmderr_clear = 1'b0;
  logic [31:0] cmd = '0;
  logic        halted_we = 1'b0, going_we = 1'b0, resuming_we = 1'b0, exception_we = 1'b0;
  logic        debug_req, busy, halted, resumeack, halt_timeout;
  logic [63:0] flags;
  logic [31:0] cmd_out;
  logic [2:0]  cmderr;

  int checks = 0;
  int errors = 0;

  dm_hart_ctrl_fsm #(.HaltTimeout(HT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .haltreq_i      (haltreq),
    .resumereq_i    (resumereq),
    .cmd_valid_i    (cmd_valid),
    .cmd_i          (cmd),
    .cmderr_clear_i (cmderr_clear),
    .halted_we_i    (halted_we),
    .going_we_i     (going_we),
    .resuming_we_i  (resuming_we),
    .exception_we_i (exception_we),
    .debug_req_o    (debug_req),
    .flags_o        (flags),
    .cmd_o          (cmd_out),
    .busy_o         (busy),
    .cmderr_o       (cmderr),
    .halted_o       (halted),
    .resumeack_o    (resumeack),
    .halt_timeout_o (halt_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the debug session described as independent phase flags.
  bit          m_halting = 0, m_halted = 0, m_go = 0, m_exec = 0, m_resuming = 0;
  bit          m_ack = 0, m_tmo = 0;
  int          m_wait = 0;
  logic [2:0]  m_err = '0, new_err;
  logic [31:0] m_cmd = '0;
  bit          busy_now, was_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halting = 0; m_halted = 0; m_go = 0; m_exec = 0; m_resuming = 0;
      m_ack = 0; m_tmo = 0; m_wait = 0; m_err = '0; m_cmd = '0;
    end else begin
      new_err    = 3'd0;
      busy_now   = m_go || m_exec;
      was_halted = m_halted;
      if (m_exec) begin
        if (exception_we) begin m_exec = 0; new_err = 3'd3; end
        else if (halted_we) m_exec = 0;
      end else if (m_go) begin
        if (going_we) begin m_go = 0; m_exec = 1; end
      end else if (m_resuming) begin
        if (resuming_we) begin m_resuming = 0; m_ack = 1; end
      end else if (m_halting) begin
        if (halted_we) begin m_halting = 0; m_halted = 1; end
        else begin
          m_wait++;
          if (m_wait == HT) begin m_halting = 0; m_tmo = 1; end
        end
      end else if (m_halted) begin
        if (cmd_valid) begin
          if (cmd[31:24] != 8'd0) new_err = 3'd2;
          else begin
            m_cmd = cmd;
            if (cmd[17] || cmd[18]) m_go = 1;
          end
        end else if (resumereq && !haltreq) begin
          m_halted = 0; m_resuming = 1; m_ack = 0;
        end
      end else begin
        if (halted_we) m_halted = 1;
        else if (haltreq) begin m_halting = 1; m_wait = 0; end
      end
      if (cmd_valid && new_err == 3'd0) begin
        if (busy_now) new_err = 3'd1;
        else if (!was_halted) new_err = 3'd4;
      end
      if (cmderr_clear) m_err = 3'd0;
      else if (m_err == 3'd0) m_err = new_err;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_debug_req", {63'd0, debug_req}, {63'd0, m_halting});
    chk("cyc_flags", flags, {62'd0, m_resuming, m_go});
    chk("cyc_busy", {63'd0, busy}, {63'd0, (m_go || m_exec)});
    chk("cyc_halted", {63'd0, halted}, {63'd0, m_halted});
    chk("cyc_resumeack", {63'd0, resumeack}, {63'd0, m_ack});
    chk("cyc_timeout", {63'd0, halt_timeout}, {63'd0, m_tmo});
    chk("cyc_cmderr", {61'd0, cmderr}, {61'd0, m_err});
    chk("cyc_cmd", {32'd0, cmd_out}, {32'd0, m_cmd});
  end

  task automatic issue_cmd(input logic [31:0] c);
    @(negedge clk); cmd = c; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  // 0 halted, 1 going, 2 resuming, 3 exception, 4 resumereq, 5 cmderr clear
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: halted_we = 1'b1;
      1: going_we = 1'b1;
      2: resuming_we = 1'b1;
      3: exception_we = 1'b1;
      4: resumereq = 1'b1;
      default: cmderr_clear = 1'b1;
    endcase
    @(negedge clk);
    halted_we = 1'b0; going_we = 1'b0; resuming_we = 1'b0;
    exception_we = 1'b0; resumereq = 1'b0; cmderr_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_outputs", {flags[7:0], cmd_out, debug_req, busy, cmderr, halted, resumeack, halt_timeout}, 64'd0);

    // Halt with HALTED written 5 cycles after the request
    @(negedge clk); haltreq = 1'b1;
    dr = 0;
    repeat (5) begin @(negedge clk); dr += int'(debug_req); end
    halted_we = 1'b1;
    @(negedge clk); halted_we = 1'b0;
    chk("halt_req_cycles", 64'(dr), 64'd5);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_req_drop", {63'd0, debug_req}, 64'd0);

    pulse(4);
    chk("resume_blocked", flags, 64'd0);

    // Abstract command with transfer
    issue_cmd(32'h0002_1008);
    chk("cmd_busy", {63'd0, busy}, 64'd1);
    chk("cmd_go_flag", flags, 64'h1);
    pulse(1);
    chk("cmd_go_clear", flags, 64'h0);
    pulse(0);
    chk("cmd_done_busy", {63'd0, busy}, 64'd0);
    chk("cmd_done_err", {61'd0, cmderr}, 64'd0);
    chk("cmd_latched", {32'd0, cmd_out}, 64'h0002_1008);

    // Exception, then busy rejection keeps the first error
    issue_cmd(32'h0002_1008);
    pulse(1);
    pulse(3);
    chk("exc_err", {61'd0, cmderr}, 64'd3);
    issue_cmd(32'h0002_1008);
    issue_cmd(32'h0003_2000);
    chk("busy_sticky", {61'd0, cmderr}, 64'd3);
    chk("busy_not_latched", {32'd0, cmd_out}, 64'h0002_1008);
    pulse(1);
    pulse(0);
    pulse(5);
    chk("clear_err", {61'd0, cmderr}, 64'd0);

    issue_cmd(32'h0100_0000);
    chk("notsup_err", {61'd0, cmderr}, 64'd2);
    chk("notsup_idle", {63'd0, busy}, 64'd0);
    pulse(5);

    // Busy error on its own, then simultaneous exception and halted
    issue_cmd(32'h0004_1000);
    issue_cmd(32'h0002_1008);
    chk("busy_err", {61'd0, cmderr}, 64'd1);
    chk("busy_cmd_kept", {32'd0, cmd_out}, 64'h0004_1000);
    pulse(1);
    pulse(5);
    @(negedge clk); exception_we = 1'b1; halted_we = 1'b1;
    @(negedge clk); exception_we = 1'b0; halted_we = 1'b0;
    chk("exc_priority", {61'd0, cmderr}, 64'd3);
    chk("exc_priority_idle", {63'd0, busy}, 64'd0);
    pulse(5);

    issue_cmd(32'h0000_1234);
    chk("noexec_busy", {63'd0, busy}, 64'd0);
    chk("noexec_latched", {32'd0, cmd_out}, 64'h0000_1234);

    @(negedge clk); cmd = 32'h0100_0000; cmd_valid = 1'b1; cmderr_clear = 1'b1;
    @(negedge clk); cmd_valid = 1'b0; cmderr_clear = 1'b0;
    chk("clear_beats_err", {61'd0, cmderr}, 64'd0);

    // Resume
    haltreq = 1'b0;
    pulse(4);
    chk("resume_flag", flags, 64'h2);
    chk("resume_not_halted", {63'd0, halted}, 64'd0);
    chk("resume_ack_clr", {63'd0, resumeack}, 64'd0);
    issue_cmd(32'h0002_1008);
    chk("resume_cmd_err", {61'd0, cmderr}, 64'd4);
    pulse(5);
    pulse(2);
    chk("resume_ack", {63'd0, resumeack}, 64'd1);
    chk("resume_flag_clr", flags, 64'h0);
    issue_cmd(32'h0002_1008);
    chk("running_cmd_err", {61'd0, cmderr}, 64'd4);
    pulse(5);

    // Halt timeout
    @(negedge clk); haltreq = 1'b1;
    repeat (9) @(negedge clk);
    chk("tmo_flag", {63'd0, halt_timeout}, 64'd1);
    chk("tmo_req_drop", {63'd0, debug_req}, 64'd0);
    chk("tmo_not_halted", {63'd0, halted}, 64'd0);
    haltreq = 1'b0;

    // Halt from running without a request (ebreak)
    pulse(0);
    chk("ebreak_halted", {63'd0, halted}, 64'd1);

    // Reset in the middle of a command
    issue_cmd(32'h0002_1008);
    chk("pre_rst_go", flags, 64'h1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {flags[7:0], cmd_out, debug_req, busy, cmderr, halted, resumeack, halt_timeout}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_running", {flags[7:0], debug_req, busy, halted, halt_timeout}, 64'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
